bist_input_seq_ctrl: RTL and testbench

- Parametrised next-generation BIST input selector for the combinational CUT (c432-class, 36 primary inputs by default).
- Adds a test-sequencing FSM around the functional/test-pattern input mux.
- Loads the TPG seed, runs exactly NUM_PATTERNS patterns into the CUT through a registered mux, enables the MISR, and signals completion.
- Sits between primary inputs / LFSR TPG and the CUT; drives the TPG and MISR enables.

---
 rtl/bist_input_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_bist_input_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_input_seq_ctrl.sv
// BIST input sequencer: seeds the TPG, runs NUM_PATTERNS patterns through a registered CUT input mux, then flushes the MISR.
// Optional per-bit functional hold during test when BIST_INPUT_MASK_EN is defined (adds port bist_mask).
module bist_input_seq_ctrl #(
   parameter int WIDTH        = 36,
   parameter int NUM_PATTERNS = 256,
   parameter int CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bist_start,
   input  logic             bist_abort,
   input  logic [WIDTH-1:0] func_in,
   input  logic [WIDTH-1:0] tpg_in,
`ifdef BIST_INPUT_MASK_EN
   input  logic [WIDTH-1:0] bist_mask,
`endif
   output logic [WIDTH-1:0] cut_in,
   output logic             tpg_load,
   output logic             tpg_en,
   output logic             misr_en,
   output logic             bist_busy,
   output logic             bist_done,
   output logic [CNT_W-1:0] pattern_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEED  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

   state_t           state_r;
   logic [WIDTH-1:0] mux_s;

   // Next CUT input: test pattern only while RUN, functional data otherwise.
   always_comb begin
      mux_s = func_in;
      if (state_r == ST_RUN) begin
`ifdef BIST_INPUT_MASK_EN
         mux_s = (tpg_in & ~bist_mask) | (func_in & bist_mask);
`else
         mux_s = tpg_in;
`endif
      end else begin
         mux_s = func_in;
      end
   end

   // Sequencer with registered decodes; flags are loaded from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cut_in      <= '0;
         misr_en     <= 1'b0;
         pattern_cnt <= '0;
         tpg_load    <= 1'b0;
         tpg_en      <= 1'b0;
         bist_busy   <= 1'b0;
         bist_done   <= 1'b0;
      end else begin
         cut_in    <= mux_s;
         misr_en   <= (state_r == ST_RUN);
         tpg_load  <= 1'b0;
         tpg_en    <= 1'b0;
         bist_busy <= 1'b0;
         bist_done <= 1'b0;
         if (bist_abort && (state_r != ST_IDLE)) begin
            // Aborted sessions keep their count for inspection and never report done.
            state_r <= ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (bist_start && !bist_abort) begin
                     state_r   <= ST_SEED;
                     tpg_load  <= 1'b1;
                     bist_busy <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               ST_SEED: begin
                  state_r     <= ST_RUN;
                  pattern_cnt <= '0;
                  tpg_en      <= 1'b1;
                  bist_busy   <= 1'b1;
               end
               ST_RUN: begin
                  pattern_cnt <= pattern_cnt + CNT_W'(1);
                  bist_busy   <= 1'b1;
                  if (pattern_cnt == LAST_CNT) begin
                     state_r <= ST_FLUSH;
                  end else begin
                     state_r <= ST_RUN;
                     tpg_en  <= 1'b1;
                  end
               end
               ST_FLUSH: begin
                  state_r   <= ST_DONE;
                  bist_done <= 1'b1;
               end
               ST_DONE: begin
                  if (bist_start) begin
                     state_r   <= ST_DONE;
                     bist_done <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bist_input_seq_ctrl.sv
// Self-checking bench for bist_input_seq_ctrl: two instances (NUM_PATTERNS 8 and 1) checked against a session-age model.
module tb_bist_input_seq_ctrl;
   localparam int W = 36;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bist_start = 1'b0;
   logic bist_abort = 1'b0;
   logic [W-1:0] func_in = '0;
   logic [W-1:0] tpg_in = '0;
   logic [W-1:0] bist_mask = '0;
   logic [W-1:0] eff_mask;

   logic [W-1:0] cut8, cut1;
   logic load8, en8, misr8, busy8, done8;
   logic load1, en1, misr1, busy1, done1;
   logic [3:0] cnt8;
   logic [0:0] cnt1;

   int n_checks = 0;
   int n_errors = 0;

`ifdef BIST_INPUT_MASK_EN
   assign eff_mask = bist_mask;
`else
   assign eff_mask = '0;
`endif

   always #5 clk = ~clk;

   bist_input_seq_ctrl #(.WIDTH(W), .NUM_PATTERNS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bist_start(bist_start), .bist_abort(bist_abort),
      .func_in(func_in), .tpg_in(tpg_in),
`ifdef BIST_INPUT_MASK_EN
      .bist_mask(bist_mask),
`endif
      .cut_in(cut8), .tpg_load(load8), .tpg_en(en8), .misr_en(misr8),
      .bist_busy(busy8), .bist_done(done8), .pattern_cnt(cnt8));

   bist_input_seq_ctrl #(.WIDTH(W), .NUM_PATTERNS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bist_start(bist_start), .bist_abort(bist_abort),
      .func_in(func_in), .tpg_in(tpg_in),
`ifdef BIST_INPUT_MASK_EN
      .bist_mask(bist_mask),
`endif
      .cut_in(cut1), .tpg_load(load1), .tpg_en(en1), .misr_en(misr1),
      .bist_busy(busy1), .bist_done(done1), .pattern_cnt(cnt1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: session age = cycles since SEED entry (-1 when idle).
   // age 0 SEED, 1..N RUN, N+1 FLUSH, N+2 DONE (held while start stays high).
   function automatic int next_age(int age, int n, logic s, logic a);
      if (age < 0) return (s && !a) ? 0 : -1;
      if (a) return -1;
      if (age >= n + 2) return s ? age : -1;
      return age + 1;
   endfunction

   function automatic int next_cnt(int age, int n, int cnt, logic s, logic a);
      int na;
      na = next_age(age, n, s, a);
      if (age >= 0 && a) return cnt;
      if (na >= 1 && na <= n + 1) return na - 1;
      return cnt;
   endfunction

   function automatic logic is_run(int age, int n);
      return (age >= 1) && (age <= n);
   endfunction

   int           m_age  [2] = '{-1, -1};
   int           m_cnt  [2] = '{0, 0};
   logic [W-1:0] m_cut  [2] = '{'0, '0};
   logic         m_misr [2] = '{1'b0, 1'b0};

   function automatic int np(int i);
      return (i == 0) ? 8 : 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_age[i]  <= -1;
            m_cnt[i]  <= 0;
            m_cut[i]  <= '0;
            m_misr[i] <= 1'b0;
         end else begin
            m_misr[i] <= is_run(m_age[i], np(i));
            m_cut[i]  <= is_run(m_age[i], np(i)) ? ((tpg_in & ~eff_mask) | (func_in & eff_mask)) : func_in;
            m_age[i]  <= next_age(m_age[i], np(i), bist_start, bist_abort);
            m_cnt[i]  <= next_cnt(m_age[i], np(i), m_cnt[i], bist_start, bist_abort);
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("cut8",  cut8,  m_cut[0]);
      chk("misr8", misr8, m_misr[0]);
      chk("cnt8",  cnt8,  m_cnt[0]);
      chk("load8", load8, m_age[0] == 0);
      chk("en8",   en8,   is_run(m_age[0], 8));
      chk("busy8", busy8, (m_age[0] >= 0) && (m_age[0] <= 9));
      chk("done8", done8, m_age[0] >= 10);
      chk("cut1",  cut1,  m_cut[1]);
      chk("misr1", misr1, m_misr[1]);
      chk("cnt1",  cnt1,  m_cnt[1]);
      chk("load1", load1, m_age[1] == 0);
      chk("en1",   en1,   is_run(m_age[1], 1));
      chk("busy1", busy1, (m_age[1] >= 0) && (m_age[1] <= 2));
      chk("done1", done1, m_age[1] >= 3);
   end

   int nl, ne, nm, ne1, nm1, t, tl, td, nd;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_cut", cut8, 64'd0);
      chk("rst_misr", misr8, 64'd0);
      chk("rst_cnt", cnt8, 64'd0);
      chk("rst_busy", busy8, 64'd0);
      chk("rst_done", done8, 64'd0);
      rst_n = 1'b1;
      func_in = 36'h0F0F0F0F0;
      tpg_in  = 36'hA5A5A5A5A;
      repeat (2) @(negedge clk);
      chk("idle_cut", cut8, 64'h0F0F0F0F0);

      // Normal session, start held high.
      bist_start = 1'b1;
      nl = 0; ne = 0; nm = 0; ne1 = 0; nm1 = 0; t = 0; tl = -1; td = -1;
      while (td < 0 && t < 60) begin
         @(negedge clk);
         t++;
         if (load8) begin nl++; if (tl < 0) tl = t; end
         if (en8) ne++;
         if (misr8) begin nm++; chk("run_cut", cut8, 64'hA5A5A5A5A); end
         if (en1) ne1++;
         if (misr1) nm1++;
         if (done8) td = t;
      end
      chk("done_timeout", td >= 0, 64'd1);
      chk("load_cycles", nl, 64'd1);
      chk("en_cycles", ne, 64'd8);
      chk("misr_cycles", nm, 64'd8);
      chk("done_latency", td - tl, 64'd10);
      chk("done_cnt", cnt8, 64'd8);
      chk("done_cut", cut8, 64'h0F0F0F0F0);
      chk("n1_en_cycles", ne1, 64'd1);
      chk("n1_misr_cycles", nm1, 64'd1);
      chk("n1_cnt", cnt1, 64'd1);
      chk("n1_done", done1, 64'd1);
      repeat (4) @(negedge clk);
      chk("done_hold", done8, 64'd1);
      bist_start = 1'b0;
      @(negedge clk);
      chk("done_drop", done8, 64'd0);

      // Abort in the third RUN cycle.
      bist_start = 1'b1;
      ne = 0; t = 0;
      while (ne < 3 && t < 20) begin
         @(negedge clk);
         t++;
         if (en8) ne++;
      end
      chk("abort_reach_run", ne, 64'd3);
      bist_abort = 1'b1;
      bist_start = 1'b0;
      @(negedge clk);
      bist_abort = 1'b0;
      chk("abort_busy", busy8, 64'd0);
      chk("abort_en", en8, 64'd0);
      chk("abort_cnt", cnt8, 64'd2);
      @(negedge clk);
      chk("abort_misr", misr8, 64'd0);
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done8) nd++;
      end
      chk("abort_no_done", nd, 64'd0);

      // Full restart with a changing pattern stream.
      bist_start = 1'b1;
      nm = 0; t = 0; td = -1;
      while (td < 0 && t < 60) begin
         @(negedge clk);
         t++;
         tpg_in = W'({$urandom(), $urandom()});
         if (misr8) nm++;
         if (done8) td = t;
      end
      chk("restart_timeout", td >= 0, 64'd1);
      chk("restart_misr", nm, 64'd8);
      chk("restart_cnt", cnt8, 64'd8);
      bist_start = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of RUN.
      bist_start = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_rst_en", en8, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cut", cut8, 64'd0);
      chk("arst_en", en8, 64'd0);
      chk("arst_misr", misr8, 64'd0);
      chk("arst_busy", busy8, 64'd0);
      chk("arst_cnt", cnt8, 64'd0);
      bist_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      func_in = 36'h123456789;
      @(negedge clk);
      chk("post_rst_cut", cut8, 64'h123456789);
      func_in = 36'hFEDCBA987;
      @(negedge clk);
      chk("post_rst_cut2", cut8, 64'hFEDCBA987);

`ifdef BIST_INPUT_MASK_EN
      func_in   = 36'h0F0F0F0F1;
      tpg_in    = 36'hA5A5A5A5A;
      bist_mask = 36'h000000001;
      bist_start = 1'b1;
      nm = 0; t = 0; td = -1;
      while (td < 0 && t < 60) begin
         @(negedge clk);
         t++;
         if (misr8) begin nm++; chk("mask_cut", cut8, 64'hA5A5A5A5B); end
         if (done8) td = t;
      end
      chk("mask_timeout", td >= 0, 64'd1);
      chk("mask_misr", nm, 64'd8);
      bist_start = 1'b0;
      @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
